// File: rtl/bnna_pcnt_pkg.sv
// Shared definitions for the BNN popcount datapath.
//   WORD_W / RES_W : popcount input word and result widths
//   pc_word_t      : one popcount input word
//   pc_res_t       : one popcount result, 2*popcount(word) - WORD_W, two's complement
//   pcnt_2p_n()    : reference for what the popcount unit computes on a word
package bnna_pcnt_pkg;

    localparam int WORD_W = 64;
    localparam int RES_W  = 8;

    typedef logic [WORD_W-1:0] pc_word_t;
    typedef logic [RES_W-1:0]  pc_res_t;

    // Bipolar popcount: +1 per set bit, -1 per clear bit.
    function automatic pc_res_t pcnt_2p_n(input pc_word_t w);
        int n;
        n = 0;
        for (int i = 0; i < WORD_W; i++) n += int'(w[i]);
        return pc_res_t'(2 * n - WORD_W);
    endfunction

endpackage

// File: rtl/pcnt_tag_fifo.sv
// In-order tag FIFO holding the requester ID of every word issued to the popcount unit.
//   clk, rst       : clock, asynchronous active-low reset (empties the FIFO)
//   push/push_data : write one tag
//   pop/pop_data   : pop_data shows the oldest tag; pop consumes it
//   empty/full     : occupancy flags
// Push and pop in the same cycle are both honoured, including when full.
// DEPTH must be a power of two, at least 2.
module pcnt_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra wrap bit distinguishes full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/popcount_rr_arbiter.sv
// Round-robin arbiter sharing one popcount pipeline among N_REQ requesters.
//   clk, rst      : clock, asynchronous active-low reset
//   req_val_i     : per-lane word valid (must not depend on req_rdy_o)
//   req_data_i    : per-lane words, lane k at [k*WORD_W +: WORD_W]
//   req_rdy_o     : one-hot grant, combinational from req_val_i and the credit count
//   rsp_val_o     : one-hot result valid, routed to the lane that issued the word
//   rsp_data_o    : result, broadcast to all lanes
//   pc_stream_o   : word to popcount unit (holds when idle)
//   pc_val_o      : word valid to popcount unit
//   pc_stream_i   : popcount result
//   pc_val_i      : popcount result valid
//   busy_o        : words are in flight
//   err_o         : sticky, a result arrived with nothing in flight
module popcount_rr_arbiter #(
    parameter int N_REQ        = 4,
    parameter int WORD_W       = bnna_pcnt_pkg::WORD_W,
    parameter int RES_W        = bnna_pcnt_pkg::RES_W,
    parameter int MAX_INFLIGHT = 8,
    parameter int ID_W         = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_val_i,
    input  logic [N_REQ*WORD_W-1:0] req_data_i,
    output logic [N_REQ-1:0]        req_rdy_o,
    output logic [N_REQ-1:0]        rsp_val_o,
    output logic [RES_W-1:0]        rsp_data_o,
    output logic [WORD_W-1:0]       pc_stream_o,
    output logic                    pc_val_o,
    input  logic [RES_W-1:0]        pc_stream_i,
    input  logic                    pc_val_i,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   grant;
    logic              any_val;
    logic [WORD_W-1:0] word_sel;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              credit_ok;
    logic              accept;
    logic              pop;
    logic [ID_W-1:0]   tag;
    logic              fifo_empty;
    logic              fifo_full;

    // First requesting lane at or after ptr, wrapping at N_REQ.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] sel;
        grant   = '0;
        any_val = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            sel = ID_W'(idx);
            if (!any_val && req_val_i[sel]) begin
                any_val = 1'b1;
                grant   = sel;
            end
        end
    end

    always_comb begin
        word_sel = '0;
        for (int k = 0; k < N_REQ; k++)
            if (grant == ID_W'(k)) word_sel = req_data_i[k*WORD_W +: WORD_W];
    end

    // Credit check uses the registered count: a return this cycle does not
    // free a slot until next cycle. fifo_full tracks cnt and is only a guard.
    assign credit_ok = (cnt < CNT_W'(MAX_INFLIGHT)) && !fifo_full;
    // Gated by rst so the ready stays low while reset is held.
    assign accept    = rst && any_val && credit_ok;
    // A result with no tag outstanding is dropped and flagged instead.
    assign pop       = pc_val_i && !fifo_empty;

    always_comb begin
        req_rdy_o = '0;
        if (accept) req_rdy_o[grant] = 1'b1;
    end

    always_comb begin
        cnt_nxt = cnt;
        if (accept && !pop)      cnt_nxt = cnt + CNT_W'(1);
        else if (!accept && pop) cnt_nxt = cnt - CNT_W'(1);
    end

    pcnt_tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (grant),
        .pop       (pop),
        .pop_data  (tag),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr         <= '0;
            cnt         <= '0;
            pc_val_o    <= 1'b0;
            pc_stream_o <= '0;
            rsp_val_o   <= '0;
            rsp_data_o  <= '0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            busy_o   <= (cnt_nxt != '0);
            pc_val_o <= accept;
            if (accept) begin
                ptr         <= (grant == ID_W'(N_REQ-1)) ? '0 : grant + ID_W'(1);
                pc_stream_o <= word_sel;
            end
            rsp_val_o <= pop ? (N_REQ'(1) << tag) : '0;
            if (pop) rsp_data_o <= pc_stream_i;
            if (pc_val_i && fifo_empty) err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_popcount_rr_arbiter.sv
module tb_popcount_rr_arbiter;
    import bnna_pcnt_pkg::*;

    localparam int N    = 4;
    localparam int W    = 64;
    localparam int R    = 8;
    localparam int MAXF = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_val_i = '0;
    logic [N*W-1:0] req_data_i = '0;
    logic [N-1:0]   req_rdy_o;
    logic [N-1:0]   rsp_val_o;
    logic [R-1:0]   rsp_data_o;
    logic [W-1:0]   pc_stream_o;
    logic           pc_val_o;
    logic [R-1:0]   pc_stream_i = '0;
    logic           pc_val_i = 1'b0;
    logic           busy_o;
    logic           err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    popcount_rr_arbiter #(
        .N_REQ(N), .WORD_W(W), .RES_W(R), .MAX_INFLIGHT(MAXF)
    ) dut (
        .clk(clk), .rst(rst),
        .req_val_i(req_val_i), .req_data_i(req_data_i), .req_rdy_o(req_rdy_o),
        .rsp_val_o(rsp_val_o), .rsp_data_o(rsp_data_o),
        .pc_stream_o(pc_stream_o), .pc_val_o(pc_val_o),
        .pc_stream_i(pc_stream_i), .pc_val_i(pc_val_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    // Snapshot of every DUT output, compared as a whole each cycle.
    typedef struct packed {
        logic [N-1:0] rdy;
        logic         pc_val;
        logic [W-1:0] pc_stream;
        logic [N-1:0] rsp_val;
        logic [R-1:0] rsp_data;
        logic         busy;
        logic         err;
    } obs_t;

    obs_t obs;
    always_comb obs = {req_rdy_o, pc_val_o, pc_stream_o, rsp_val_o, rsp_data_o, busy_o, err_o};

    // Behavioural popcount unit: fixed latency lat, cleared by reset; inj forces a stray result.
    int          lat = 3;
    logic        inj = 1'b0;
    logic [R-1:0] inj_d = '0;
    logic        pv [64];
    logic [R-1:0] pd [64];

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            for (int k = 0; k < 64; k++) begin pv[k] = 1'b0; pd[k] = '0; end
        end else begin
            for (int k = 63; k > 0; k--) begin pv[k] = pv[k-1]; pd[k] = pd[k-1]; end
            pv[0] = pc_val_o;
            pd[0] = pcnt_2p_n(pc_stream_o);
        end
        pc_val_i    = pv[lat] | inj;
        pc_stream_i = inj ? inj_d : pd[lat];
    end

    // Reference model: round-robin pointer plus the queue of issued (lane, word) pairs.
    int           m_ptr;
    int           lane_q [$];
    logic [W-1:0] word_q [$];
    obs_t         m_reg;

    task automatic model_reset();
        m_ptr = 0;
        lane_q.delete();
        word_q.delete();
        m_reg = '0;
    endtask

    function automatic logic [N*W-1:0] rnd_data();
        logic [N*W-1:0] r;
        for (int i = 0; i < N*W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Drive one cycle of requests; return what every output should show in this cycle.
    task automatic drive_cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, output obs_t e);
        int           g;
        int           l;
        logic         acc;
        logic [W-1:0] wd;
        @(negedge clk);
        req_val_i  = v;
        req_data_i = d;
        #1;
        e     = m_reg;
        e.rdy = '0;
        g = -1;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (g < 0 && v[k]) g = k;
        end
        acc = (g >= 0) && (lane_q.size() < MAXF);
        if (acc) e.rdy[g] = 1'b1;
        m_reg.pc_val  = acc;
        m_reg.rsp_val = '0;
        if (pc_val_i) begin
            if (lane_q.size() > 0) begin
                l  = lane_q.pop_front();
                wd = word_q.pop_front();
                m_reg.rsp_val[l] = 1'b1;
                m_reg.rsp_data   = pcnt_2p_n(wd);
            end else begin
                m_reg.err = 1'b1;
            end
        end
        if (acc) begin
            wd = d[g*W +: W];
            lane_q.push_back(g);
            word_q.push_back(wd);
            m_ptr = (g + 1) % N;
            m_reg.pc_stream = wd;
        end
        m_reg.busy = (lane_q.size() != 0);
    endtask

    task automatic do_reset(input logic [N-1:0] v);
        @(negedge clk);
        rst = 1'b0; req_val_i = v; req_data_i = rnd_data(); inj = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        req_val_i  = '1;
        req_data_i = rnd_data();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs cyc%0d got=%h exp=0", i, obs); end
        end
    endtask

    task automatic test_single_word();
        obs_t           e;
        logic [N*W-1:0] d;
        logic [N-1:0]   lanes [2];
        logic [R-1:0]   res   [2];
        lanes[0] = 4'b0100; res[0] = 8'h40;
        lanes[1] = 4'b0010; res[1] = 8'hC0;
        do_reset('0);
        lat = 3;
        for (int t = 0; t < 2; t++) begin
            d = rnd_data();
            d[(t == 0 ? 2 : 1)*W +: W] = (t == 0) ? '1 : '0;
            drive_cycle(lanes[t], d, e);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL single%0d_cyc0 got=%h exp=%h", t, obs, e); end
            n_checks++;
            if (req_rdy_o !== lanes[t]) begin n_fail++; $display("FAIL single%0d_grant got=%b exp=%b", t, req_rdy_o, lanes[t]); end
            for (int i = 1; i <= 8; i++) begin
                drive_cycle('0, rnd_data(), e);
                n_checks++;
                if (obs !== e) begin n_fail++; $display("FAIL single%0d_cyc%0d got=%h exp=%h", t, i, obs, e); end
                if (i == 1) begin
                    n_checks++;
                    if (pc_val_o !== 1'b1 || pc_stream_o !== d[(t == 0 ? 2 : 1)*W +: W]) begin
                        n_fail++; $display("FAIL single%0d_issue got=%b/%h", t, pc_val_o, pc_stream_o);
                    end
                end
                if (i == 2 + lat) begin
                    n_checks++;
                    if (rsp_val_o !== lanes[t] || rsp_data_o !== res[t]) begin
                        n_fail++; $display("FAIL single%0d_rsp got=%b/%h exp=%b/%h", t, rsp_val_o, rsp_data_o, lanes[t], res[t]);
                    end
                end
            end
        end
    endtask

    task automatic test_fairness();
        obs_t         e;
        logic [N-1:0] one;
        one = 1;
        do_reset('1);
        lat = 4;
        for (int i = 0; i < 40; i++) begin
            drive_cycle('1, rnd_data(), e);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL fair_cyc%0d got=%h exp=%h", i, obs, e); end
            n_checks++;
            if (req_rdy_o !== (one << (i % N))) begin
                n_fail++; $display("FAIL fair_order cyc%0d got=%b exp=%b", i, req_rdy_o, one << (i % N));
            end
        end
    endtask

    task automatic test_credit_limit();
        obs_t e;
        int   acc_before;
        logic seen_ret;
        do_reset('1);
        lat = 20;
        acc_before = 0;
        seen_ret = 1'b0;
        for (int i = 0; i < 60; i++) begin
            drive_cycle('1, rnd_data(), e);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL credit_cyc%0d got=%h exp=%h", i, obs, e); end
            if (!seen_ret) begin
                if (acc_before >= MAXF) begin
                    n_checks++;
                    if (req_rdy_o !== '0) begin n_fail++; $display("FAIL credit_stall cyc%0d got=%b exp=0", i, req_rdy_o); end
                end
                if (|(req_val_i & req_rdy_o)) acc_before++;
            end
            if (pc_val_i) seen_ret = 1'b1;
            if (i >= 1) begin
                n_checks++;
                if (busy_o !== 1'b1) begin n_fail++; $display("FAIL credit_busy cyc%0d got=%b exp=1", i, busy_o); end
            end
        end
        n_checks++;
        if (acc_before != MAXF || !seen_ret) begin
            n_fail++; $display("FAIL credit_count got=%0d exp=%0d", acc_before, MAXF);
        end
    endtask

    task automatic test_simultaneous();
        obs_t         e;
        logic [N-1:0] v;
        do_reset('0);
        lat = 6;
        // 7 accepts fill to cnt=7; from then on every cycle has an accept and a return.
        for (int i = 0; i < 30; i++) begin
            v = N'($urandom_range(1, (1 << N) - 1));
            drive_cycle(v, rnd_data(), e);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL simul_cyc%0d got=%h exp=%h", i, obs, e); end
            if (i >= 7) begin
                n_checks++;
                if (req_rdy_o === '0) begin n_fail++; $display("FAIL simul_credit cyc%0d got=%b exp=nonzero", i, req_rdy_o); end
            end
        end
    endtask

    task automatic test_spurious();
        obs_t e;
        do_reset('0);
        lat = 3;
        for (int i = 0; i < 3; i++) begin
            drive_cycle('0, rnd_data(), e);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL spur_idle%0d got=%h exp=%h", i, obs, e); end
        end
        inj   = 1'b1;
        inj_d = R'($urandom);
        drive_cycle('0, rnd_data(), e);
        inj = 1'b0;
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL spur_pulse got=%h exp=%h", obs, e); end
        for (int i = 0; i < 5; i++) begin
            drive_cycle('0, rnd_data(), e);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL spur_after%0d got=%h exp=%h", i, obs, e); end
            n_checks++;
            if (err_o !== 1'b1 || rsp_val_o !== '0 || busy_o !== 1'b0) begin
                n_fail++; $display("FAIL spur_state cyc%0d got err=%b rsp=%b busy=%b exp 1/0/0", i, err_o, rsp_val_o, busy_o);
            end
        end
        // The stray pulse must not have disturbed the count: normal traffic still works.
        for (int i = 0; i < 12; i++) begin
            drive_cycle(i < 2 ? 4'b1000 : 4'b0000, rnd_data(), e);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL spur_traffic%0d got=%h exp=%h", i, obs, e); end
        end
    endtask

    task automatic test_mid_reset();
        obs_t e;
        do_reset('0);
        lat = 10;
        for (int i = 0; i < 5; i++) begin
            drive_cycle('1, rnd_data(), e);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL midrst_fill%0d got=%h exp=%h", i, obs, e); end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (obs !== '0) begin n_fail++; $display("FAIL midrst_outputs cyc%0d got=%h exp=0", i, obs); end
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        drive_cycle(4'b0110, rnd_data(), e);
        n_checks++;
        if (req_rdy_o !== 4'b0010 || err_o !== 1'b0) begin
            n_fail++; $display("FAIL midrst_first got rdy=%b err=%b exp 0010/0", req_rdy_o, err_o);
        end
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL midrst_cyc0 got=%h exp=%h", obs, e); end
        for (int i = 1; i < 25; i++) begin
            drive_cycle(N'($urandom), rnd_data(), e);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL midrst_cyc%0d got=%h exp=%h", i, obs, e); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_word();
        test_fairness();
        test_credit_limit();
        test_simultaneous();
        test_spurious();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
